pipe_step_ctrl: RTL and testbench

- Parametrised button conditioner and step sequencer for the manually clocked pipeline.
- Synchronises and debounces NBTN raw push-buttons, then produces clean levels and one-cycle rising-edge pulses.
- Channel 0 triggers a step FSM that drives the pipeline step enable in one of four modes: single step, counted burst, free-run, or hold.
- Sits between the board buttons and the pipeline top; replaces direct use of raw buttons as clock/selects.

---
 rtl/pipe_step_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_step_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_step_ctrl.sv
// Button conditioner (2-flop sync + debounce + rise detect) feeding a step
// sequencer that drives the pipeline step enable in single/burst/run/hold modes.
module pipe_step_ctrl #(
  parameter int NBTN       = 4,
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5,
  parameter int BURST_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NBTN-1:0]    btn_raw,
  input  logic [1:0]         mode,
  input  logic [BURST_W-1:0] burst_len,
  output logic [NBTN-1:0]    btn_level,
  output logic [NBTN-1:0]    btn_rise,
  output logic               step_en,
  output logic               busy,
  output logic [15:0]        step_count
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    RUN
  } state_t;

  state_t             state;
  logic [NBTN-1:0]    syncA;
  logic [NBTN-1:0]    syncB;
  logic [DEB_W-1:0]   debCnt [NBTN];
  logic [NBTN-1:0]    levelNext;
  logic [BURST_W-1:0] remaining;
  logic               trig;
  logic               holdMode;

  assign trig     = btn_rise[0];
  assign holdMode = (mode == 2'b11);

  // A level flips on the DEB_CYCLES-th consecutive mismatching sample.
  always_comb begin
    levelNext = btn_level;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (syncB[i] != btn_level[i] && debCnt[i] == DEB_W'(DEB_CYCLES - 1))
        levelNext[i] = ~btn_level[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncA     <= '0;
      syncB     <= '0;
      btn_level <= '0;
      btn_rise  <= '0;
      for (int unsigned i = 0; i < NBTN; i++) debCnt[i] <= '0;
    end else begin
      syncA     <= btn_raw;
      syncB     <= syncA;
      btn_level <= levelNext;
      btn_rise  <= levelNext & ~btn_level;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (syncB[i] == btn_level[i] || levelNext[i] != btn_level[i])
          debCnt[i] <= '0;
        else
          debCnt[i] <= debCnt[i] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      step_en    <= 1'b0;
      busy       <= 1'b0;
      step_count <= '0;
    end else begin
      step_count <= step_count + {15'b0, step_en};
      case (state)
        IDLE: begin
          step_en <= 1'b0;
          busy    <= 1'b0;
          if (trig) begin
            case (mode)
              2'b00: step_en <= 1'b1;
              2'b01: begin
                if (burst_len != '0) begin
                  remaining <= burst_len;
                  state     <= BURST;
                  step_en   <= 1'b1;
                  busy      <= 1'b1;
                end
              end
              2'b10: begin
                state   <= RUN;
                step_en <= 1'b1;
                busy    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // remaining counts the step currently on step_en, so 1 means last one.
        BURST: begin
          if (holdMode || remaining == BURST_W'(1)) begin
            state     <= IDLE;
            remaining <= '0;
            step_en   <= 1'b0;
            busy      <= 1'b0;
          end else begin
            remaining <= remaining - BURST_W'(1);
            step_en   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (holdMode || trig) begin
            state   <= IDLE;
            step_en <= 1'b0;
            busy    <= 1'b0;
          end else begin
            step_en <= 1'b1;
            busy    <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
          step_en   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Self-checking bench for pipe_step_ctrl: cycle model of the button window
// rule and step schedule, plus directed checks with hand-derived values.
module tb_pipe_step_ctrl;
  localparam int NBTN = 4;
  localparam int DEB  = 16;
  localparam int BW   = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NBTN-1:0] btn_raw = '0;
  logic [1:0]      mode = 2'b00;
  logic [BW-1:0]   burst_len = '0;
  logic [NBTN-1:0] btn_level;
  logic [NBTN-1:0] btn_rise;
  logic            step_en;
  logic            busy;
  logic [15:0]     step_count;

  pipe_step_ctrl #(.NBTN(NBTN), .DEB_CYCLES(DEB), .DEB_W(5), .BURST_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .mode(mode),
    .burst_len(burst_len), .btn_level(btn_level), .btn_rise(btn_rise),
    .step_en(step_en), .busy(busy), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a level flips when the last DEB synchronised samples all differ
  // from it; steps are scheduled as cycle ranges rather than states.
  logic [DEB:0]    hist [NBTN] = '{default: '0};
  logic [NBTN-1:0] mLevel = '0;
  logic [NBTN-1:0] mRise = '0;
  longint mCyc = 0, bs = 1, be = 0, singleAt = -1;
  bit     runOn = 0;
  int     mCount = 0;
  bit     mTrig, allDiff;

  function automatic bit mInBurst();
    return (mCyc >= bs) && (mCyc <= be);
  endfunction

  function automatic bit mStep();
    return (mCyc == singleAt) || mInBurst() || runOn;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int ch = 0; ch < NBTN; ch++) hist[ch] = '0;
      mLevel = '0; mRise = '0; mCyc = 0; bs = 1; be = 0; singleAt = -1;
      runOn = 0; mCount = 0;
    end else begin
      mTrig = mRise[0];
      if (mStep()) mCount = (mCount + 1) % 65536;
      if (runOn) begin
        if (mode == 2'b11 || mTrig) runOn = 0;
      end else if (mInBurst()) begin
        if (mode == 2'b11) be = mCyc;
      end else if (mTrig) begin
        case (mode)
          2'b00: singleAt = mCyc + 1;
          2'b01: if (burst_len != 0) begin bs = mCyc + 1; be = mCyc + burst_len; end
          2'b10: runOn = 1;
          default: ;
        endcase
      end
      for (int ch = 0; ch < NBTN; ch++) begin
        allDiff = 1;
        for (int k = 1; k <= DEB; k++) if (hist[ch][k] == mLevel[ch]) allDiff = 0;
        mRise[ch] = allDiff && !mLevel[ch];
        if (allDiff) mLevel[ch] = ~mLevel[ch];
        hist[ch] = {hist[ch][DEB-1:0], btn_raw[ch]};
      end
      mCyc++;
    end
  end

  longint cyc = 0;
  int riseCnt0, riseCnt1, stepCnt, busyCnt;
  longint firstStep, lastStep, firstRise0, lastRise0;
  bit lvl1Seen;

  initial forever begin
    @(negedge clk);
    check("btn_level", btn_level, mLevel);
    check("btn_rise", btn_rise, mRise);
    check("step_en", step_en, mStep());
    check("busy", busy, mInBurst() || runOn);
    check("step_count", step_count, mCount);
    if (btn_rise[0]) begin
      riseCnt0++;
      if (firstRise0 < 0) firstRise0 = cyc;
      lastRise0 = cyc;
    end
    if (btn_rise[1]) riseCnt1++;
    if (btn_level[1]) lvl1Seen = 1;
    if (step_en) begin
      stepCnt++;
      if (firstStep < 0) firstStep = cyc;
      lastStep = cyc;
    end
    if (busy) busyCnt++;
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clearStats();
    riseCnt0 = 0; riseCnt1 = 0; stepCnt = 0; busyCnt = 0; lvl1Seen = 0;
    firstStep = -1; lastStep = -1; firstRise0 = -1; lastRise0 = -1;
  endtask

  task automatic press(input int ch, input int hold, input int rel);
    btn_raw[ch] = 1'b1; tick(hold);
    btn_raw[ch] = 1'b0; tick(rel);
  endtask

  int     base;
  int     n;
  bit     found;

  initial begin
    rst_n = 1'b0;
    clearStats();
    tick(3);
    check("rst_level", btn_level, 0);
    check("rst_rise", btn_rise, 0);
    check("rst_step_en", step_en, 0);
    check("rst_busy", busy, 0);
    check("rst_count", step_count, 0);
    rst_n = 1'b1;
    tick(3);
    check("idle_count", step_count, 0);

    // Glitch shorter than the debounce window, then a held press.
    clearStats();
    btn_raw[1] = 1'b1; tick(5); btn_raw[1] = 1'b0; tick(30);
    check("glitch_level_seen", lvl1Seen, 0);
    check("glitch_rise_cnt", riseCnt1, 0);
    btn_raw[1] = 1'b1;
    n = 0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1; n++;
      if (btn_level[1]) found = 1;
    end
    check("hold_latency", n, 18);
    tick(12);
    btn_raw[1] = 1'b0; tick(25);
    check("hold_rise_cnt", riseCnt1, 1);

    // Single steps.
    clearStats();
    mode = 2'b00;
    base = step_count;
    repeat (3) press(0, 22, 22);
    check("single_rises", riseCnt0, 3);
    check("single_steps", stepCnt, 3);
    check("single_count", step_count, base + 3);
    check("single_busy", busyCnt, 0);

    // Burst of 5.
    clearStats();
    mode = 2'b01; burst_len = 6'd5;
    base = step_count;
    press(0, 22, 24);
    check("burst5_steps", stepCnt, 5);
    check("burst5_busy", busyCnt, 5);
    check("burst5_first", firstStep, firstRise0 + 1);
    check("burst5_last", lastStep, firstRise0 + 5);
    check("burst5_count", step_count, base + 5);

    // Burst of 60 with a second trigger landing inside it.
    clearStats();
    burst_len = 6'd60;
    press(0, 20, 18);
    press(0, 22, 40);
    check("burst60_rises", riseCnt0, 2);
    check("burst60_mid", (lastRise0 < firstRise0 + 60) ? 1 : 0, 1);
    check("burst60_steps", stepCnt, 60);
    check("burst60_busy", busyCnt, 60);

    // Free run stopped by a second trigger.
    clearStats();
    mode = 2'b10;
    press(0, 22, 22);
    tick(40);
    press(0, 22, 22);
    check("run_first", firstStep, firstRise0 + 1);
    check("run_last", lastStep, lastRise0);
    check("run_contig", stepCnt, lastStep - firstStep + 1);
    check("run_stopped", step_en, 0);

    // Free run stopped by hold mode.
    press(0, 22, 0);
    tick(10);
    check("hold_run_active", step_en, 1);
    mode = 2'b11;
    tick(1);
    check("hold_stop_step", step_en, 0);
    check("hold_stop_busy", busy, 0);
    tick(25);

    // Long run up to the wrap region, then a burst across the wrap.
    mode = 2'b10;
    press(0, 22, 22);
    found = 0;
    for (int i = 0; i < 70000 && !found; i++) begin
      tick(1);
      if (step_count == 16'hFFF8) found = 1;
    end
    check("reach_fff8", found, 1);
    mode = 2'b11;
    tick(2);
    mode = 2'b01; burst_len = 6'd40;
    btn_raw[0] = 1'b1;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(1);
      if (step_count == 16'hFFFF) found = 1;
    end
    check("reach_ffff", found, 1);
    tick(1);
    check("wrap_zero", step_count, 0);
    tick(3);
    check("mid_burst_busy", busy, 1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    btn_raw = '0;
    #1;
    check("arst_level", btn_level, 0);
    check("arst_rise", btn_rise, 0);
    check("arst_step_en", step_en, 0);
    check("arst_busy", busy, 0);
    check("arst_count", step_count, 0);
    tick(3);
    rst_n = 1'b1;
    mode = 2'b00;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
